df_actor_responder: RTL
=======================

DF_ACTOR_RESPONDER -- requirements
Module: df_actor_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32; token width, at least 2.
REQ-002 Parameter LATENCY, default 2; compute cycles per firing, 1 to 255.
REQ-003 Parameter OFFSET, default 1; constant added to each consumed token.
REQ-004 clk  in  1  clock; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ap_start  in  1  firing request from the scheduling controller.
REQ-007 ap_done  out  1  one-cycle pulse ending a firing attempt.
REQ-008 ap_ready  out  1  equal to ap_done.
REQ-009 ap_idle  out  1  high while in IDLE.
REQ-010 ap_return  out  32  attempt result code, held until the next attempt completes.
REQ-011 in_dout  in  DATA_WIDTH  head token of the first-word-fall-through input FIFO.
REQ-012 in_empty_n  in  1  input FIFO holds at least 1 token.
REQ-013 in_read  out  1  pops 1 input token.
REQ-014 out_din  out  DATA_WIDTH  output token.
REQ-015 out_full_n  in  1  output FIFO has space.
REQ-016 out_write  out  1  pushes out_din.

Function
REQ-017 Return codes: IDLE=0, WAIT_PREDICATE=1, WAIT_INPUT=2, WAIT_OUTPUT=3, WAIT_GUARD=4, EXECUTED=5.
REQ-018 States: IDLE, CHECK, READ, COMPUTE, WRITE, DONE.
REQ-019 IDLE: ap_start=1 -> CHECK; otherwise remain in IDLE.
REQ-020 CHECK, first matching rule applies:
- in_empty_n=0 -> code WAIT_INPUT, go to DONE.
- guard fails (REQ-031) -> code WAIT_GUARD, go to DONE.
- out_full_n=0 -> code WAIT_OUTPUT, go to DONE.
- otherwise -> READ.
REQ-021 READ: in_read=1 for exactly 1 cycle; in_dout+OFFSET, modulo 2^DATA_WIDTH, is captured into the result register; go to COMPUTE.
REQ-022 COMPUTE: a counter holds for exactly LATENCY cycles, then goes to WRITE.
REQ-023 WRITE: out_write=1 and out_din=result in the first cycle with out_full_n=1, then go to DONE with code EXECUTED; while out_full_n=0, stay in WRITE with out_write=0.
REQ-024 DONE: ap_done=ap_ready=1 for 1 cycle; ap_return carries the code from that cycle onward.
- ap_start=1 in DONE -> CHECK, back-to-back firing with no IDLE cycle.
- ap_start=0 in DONE -> IDLE.
REQ-025 Cycle timing, with ap_start sampled in cycle 0:
- wait results: ap_done in cycle 2.
- EXECUTED with no output stall: in_read in cycle 2, out_write in cycle 3+LATENCY, ap_done in cycle 4+LATENCY.
REQ-026 ap_start is ignored in CHECK, READ, COMPUTE and WRITE.
REQ-027 A wait result never asserts in_read or out_write; the input token is left unconsumed.
REQ-028 in_read and out_write are never high in the same cycle; at most 1 token in and 1 token out per firing.

Reset
REQ-029 rst=1 at a clock edge forces the following, overriding all other inputs, including mid-firing:
- state IDLE, ap_return=0, counter=0, result=0.
- ap_done=0, ap_ready=0, in_read=0, out_write=0, out_din=0, ap_idle=1.
REQ-030 A firing interrupted by reset never completes; no out_write occurs after reset even if a token was already consumed.

Configuration
REQ-031 Macro DF_ACTOR_RESPONDER_GUARD_EN:
- Defined: the guard fails when in_dout[DATA_WIDTH-1]=1.
- Undefined: the guard always passes and WAIT_GUARD is never returned.

Verification
REQ-032 in_empty_n=0, ap_start pulse in cycle 0 -> ap_done=1 in cycle 2, ap_return=2, no in_read.
REQ-033 in_dout=0x00000007, in_empty_n=1, out_full_n=1, LATENCY=2, OFFSET=1 -> in_read in cycle 2, out_write with out_din=0x00000008 in cycle 5, ap_done in cycle 6, ap_return=5.
REQ-034 in_dout=0x80000000 with GUARD_EN defined -> ap_return=4, no in_read; same stimulus with GUARD_EN undefined -> out_din=0x80000001, ap_return=5.
REQ-035 in_dout=0xFFFFFFFF with GUARD_EN undefined -> out_din=0x00000000 (wrap-around).
REQ-036 out_full_n=0 in CHECK -> ap_return=3; out_full_n dropped for 3 cycles during WRITE -> out_write delayed exactly 3 cycles, ap_done 1 cycle after the write.
REQ-037 Two cases:
- ap_start held high across DONE -> a second firing begins with no IDLE cycle.
- rst=1 during COMPUTE -> no out_write, ap_return=0, ap_idle=1 the next cycle.

Source files
------------

// File: rtl/df_actor_responder.sv
// Dataflow actor: per firing, pop one token, add OFFSET, push the result, and report a result code.
// Latency: a wait result ends in 2 cycles after ap_start; an executed firing ends in 4+LATENCY cycles plus output stalls.
// Backpressure: empty input or full output at CHECK ends the attempt unconsumed; a full output during WRITE holds the write.
//
// Ports: clk/rst (synchronous, active-high); ap_start/ap_done/ap_ready/ap_idle/ap_return form the
// block-level handshake; in_dout/in_empty_n/in_read attach to a FWFT input FIFO; out_din/out_full_n/out_write
// attach to the output FIFO.
// Optional feature: define DF_ACTOR_RESPONDER_GUARD_EN to refuse tokens whose MSB is set (code WAIT_GUARD).
module df_actor_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int OFFSET     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic [31:0]           ap_return,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty_n,
    output logic                  in_read,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full_n,
    output logic                  out_write
);

    localparam logic [31:0] RC_WAIT_INPUT  = 32'd2;
    localparam logic [31:0] RC_WAIT_OUTPUT = 32'd3;
    localparam logic [31:0] RC_WAIT_GUARD  = 32'd4;
    localparam logic [31:0] RC_EXECUTED    = 32'd5;

    localparam logic [DATA_WIDTH-1:0] OFFSET_W = DATA_WIDTH'(OFFSET);
    localparam logic [7:0]            CNT_LAST = 8'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   result, result_nxt;
    logic [31:0]             code_nxt;
    logic                    code_ld;
    logic                    guard_ok;

`ifdef DF_ACTOR_RESPONDER_GUARD_EN
    assign guard_ok = ~in_dout[DATA_WIDTH-1];
`else
    assign guard_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            result    <= '0;
            ap_return <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            result <= result_nxt;
            // The code is latched on entry to DONE so it is visible during the ap_done cycle.
            if (code_ld) begin
                ap_return <= code_nxt;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        result_nxt = result;
        code_nxt   = '0;
        code_ld    = 1'b0;
        in_read    = 1'b0;
        out_write  = 1'b0;
        ap_done    = 1'b0;
        ap_idle    = 1'b0;

        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!in_empty_n) begin
                    code_nxt  = RC_WAIT_INPUT;
                    code_ld   = 1'b1;
                    state_nxt = S_DONE;
                end else if (!guard_ok) begin
                    code_nxt  = RC_WAIT_GUARD;
                    code_ld   = 1'b1;
                    state_nxt = S_DONE;
                end else if (!out_full_n) begin
                    code_nxt  = RC_WAIT_OUTPUT;
                    code_ld   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                in_read    = 1'b1;
                result_nxt = in_dout + OFFSET_W;
                cnt_nxt    = '0;
                state_nxt  = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WRITE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_WRITE: begin
                // Output space is re-checked here; a full FIFO simply stretches this state.
                if (out_full_n) begin
                    out_write = 1'b1;
                    code_nxt  = RC_EXECUTED;
                    code_ld   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ap_done   = 1'b1;
                state_nxt = ap_start ? S_CHECK : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign ap_ready = ap_done;
    assign out_din  = result;

endmodule
